mem_stage: RTL and testbench

- Memory stage of the in-order RISC-V pipeline. Sits between the EX/MEM register and the writeback stage.
- Initiator/driver of the MEMWB interface. Accepts one EX/MEM op at a time and, for loads, issues one request to the data cache and waits for the response.
- Presents the result on MEMWB_* with a one-cycle MEMWB_ready pulse.
- Stores are not written here. They are forwarded as a pending write (MEMWB_pend_write/addr/value/size), which writeback commits.

---
 rtl/mem_stage_pkg.sv | 37 +++
 rtl/mem_stage_if.sv | 49 ++++
 rtl/mem_stage_load_align.sv | 19 +
 rtl/mem_stage.sv | 128 ++++++++++++
 tb/tb_mem_stage.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, FSM states, captured-op record and alignment/store-mask helpers.
package mem_stage_pkg;
    localparam int XLEN = 64;
    localparam int RD_W = 6;
    localparam int SIZE_W = 4;
    localparam logic [SIZE_W-1:0] SZ_B = 4'd1;
    localparam logic [SIZE_W-1:0] SZ_H = 4'd2;
    localparam logic [SIZE_W-1:0] SZ_W = 4'd4;
    localparam logic [SIZE_W-1:0] SZ_D = 4'd8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   sdata;
        logic              is_load;
        logic              is_store;
        logic [SIZE_W-1:0] size;
        logic              uns;
        logic              wb;
        logic              ecall;
        logic              fault;
    } op_t;

    function automatic logic is_aligned(input logic [XLEN-1:0] addr, input logic [SIZE_W-1:0] size);
        return size == SZ_B ? 1'b1 :
               size == SZ_H ? ~addr[0] :
               size == SZ_W ? addr[1:0] == 2'b00 : addr[2:0] == 3'b000;
    endfunction

    function automatic logic [XLEN-1:0] store_mask(input logic [XLEN-1:0] value, input logic [SIZE_W-1:0] size);
        return size == SZ_B ? {{(XLEN-8){1'b0}}, value[7:0]} :
               size == SZ_H ? {{(XLEN-16){1'b0}}, value[15:0]} :
               size == SZ_W ? {{(XLEN-32){1'b0}}, value[31:0]} : value;
    endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs, data-cache request/response and MEMWB outputs of the memory stage.
interface mem_stage_if;
    import mem_stage_pkg::*;
    logic              exmem_valid;
    logic [RD_W-1:0]   exmem_rd;
    logic [XLEN-1:0]   exmem_aluresult;
    logic [XLEN-1:0]   exmem_store_data;
    logic              exmem_is_load;
    logic              exmem_is_store;
    logic [SIZE_W-1:0] exmem_size;
    logic              exmem_unsigned;
    logic              exmem_wbactive;
    logic              exmem_ecall;
    logic              exmem_stall;
    logic              dreq_valid;
    logic [XLEN-1:0]   dreq_addr;
    logic              dreq_ready;
    logic              dresp_valid;
    logic [XLEN-1:0]   dresp_data;
    logic [RD_W-1:0]   MEMWB_dest_reg;
    logic [XLEN-1:0]   MEMWB_aluresult;
    logic [XLEN-1:0]   MEMWB_loadeddata;
    logic              MEMWB_dataselect;
    logic              MEMWB_wbactive;
    logic              MEMWB_ready;
    logic              MEMWB_ecall;
    logic              MEMWB_pend_write;
    logic [SIZE_W-1:0] MEMWB_size;
    logic [XLEN-1:0]   MEMWB_value;
    logic [XLEN-1:0]   MEMWB_addr;
    logic              MEMWB_fault;

    modport master (
        input  exmem_valid, exmem_rd, exmem_aluresult, exmem_store_data, exmem_is_load,
               exmem_is_store, exmem_size, exmem_unsigned, exmem_wbactive, exmem_ecall,
               dreq_ready, dresp_valid, dresp_data,
        output exmem_stall, dreq_valid, dreq_addr, MEMWB_dest_reg, MEMWB_aluresult,
               MEMWB_loadeddata, MEMWB_dataselect, MEMWB_wbactive, MEMWB_ready, MEMWB_ecall,
               MEMWB_pend_write, MEMWB_size, MEMWB_value, MEMWB_addr, MEMWB_fault
    );
    modport slave (
        output exmem_valid, exmem_rd, exmem_aluresult, exmem_store_data, exmem_is_load,
               exmem_is_store, exmem_size, exmem_unsigned, exmem_wbactive, exmem_ecall,
               dreq_ready, dresp_valid, dresp_data,
        input  exmem_stall, dreq_valid, dreq_addr, MEMWB_dest_reg, MEMWB_aluresult,
               MEMWB_loadeddata, MEMWB_dataselect, MEMWB_wbactive, MEMWB_ready, MEMWB_ecall,
               MEMWB_pend_write, MEMWB_size, MEMWB_value, MEMWB_addr, MEMWB_fault
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: picks the addressed lane of a doubleword and sign/zero-extends it to XLEN.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0]   dword_i,
    input  logic [2:0]        lane_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic              unsigned_i,
    output logic [XLEN-1:0]   data_o
);
    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = dword_i >> {lane_i, 3'b000};
        data_o = size_i == SZ_B ? {{(XLEN-8){~unsigned_i & shifted[7]}}, shifted[7:0]} :
                 size_i == SZ_H ? {{(XLEN-16){~unsigned_i & shifted[15]}}, shifted[15:0]} :
                 size_i == SZ_W ? {{(XLEN-32){~unsigned_i & shifted[31]}}, shifted[31:0]} : shifted;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; loads go through the data cache, stores are handed to writeback.
// Define MEM_STORE_FWD_EN to let loads covered by the last store bypass the cache.
module mem_stage
    import mem_stage_pkg::*;
(
    input logic clk,
    input logic reset,
    mem_stage_if.master bus
);
    state_t state_q, state_d;
    op_t op_in, op_q, cur;
    logic fault_in, fwd_hit, resp_enter;
    logic [XLEN-1:0] ld_dword, ld_ext;
    logic [RD_W-1:0] dest_q;
    logic [XLEN-1:0] alu_q, ld_q, value_q, addr_q;
    logic [SIZE_W-1:0] size_q;
    logic dsel_q, wb_q, ecall_q, pw_q, fault_q;

    // A load+store combination is illegal and is reported as a faulting load.
    assign fault_in = (bus.exmem_is_load | bus.exmem_is_store) &
                      (~is_aligned(bus.exmem_aluresult, bus.exmem_size) | (bus.exmem_is_load & bus.exmem_is_store));
    assign op_in = '{rd: bus.exmem_rd, alu: bus.exmem_aluresult, sdata: bus.exmem_store_data,
                     is_load: bus.exmem_is_load, is_store: bus.exmem_is_store & ~bus.exmem_is_load,
                     size: bus.exmem_size, uns: bus.exmem_unsigned,
                     wb: bus.exmem_wbactive & ~fault_in, ecall: bus.exmem_ecall, fault: fault_in};
    assign cur = state_q == IDLE ? op_in : op_q;
    assign resp_enter = state_d == RESP && state_q != RESP;

`ifdef MEM_STORE_FWD_EN
    logic buf_valid_q;
    logic [XLEN-1:0] buf_addr_q, buf_value_q;
    logic [SIZE_W-1:0] buf_size_q;
    logic [3:0] ld_lo, ld_hi, st_lo, st_hi;
    assign ld_lo = {1'b0, bus.exmem_aluresult[2:0]};
    assign ld_hi = ld_lo + bus.exmem_size;
    assign st_lo = {1'b0, buf_addr_q[2:0]};
    assign st_hi = st_lo + buf_size_q;
    assign fwd_hit = buf_valid_q && bus.exmem_aluresult[XLEN-1:3] == buf_addr_q[XLEN-1:3] &&
                     ld_lo >= st_lo && ld_hi <= st_hi;
    // Buffered stores are aligned, so shifting into their lane rebuilds the doubleword view.
    assign ld_dword = state_q == IDLE ? buf_value_q << {buf_addr_q[2:0], 3'b000} : bus.dresp_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_addr_q <= '0;
            buf_value_q <= '0;
            buf_size_q <= '0;
        end else if (state_q == RESP && op_q.is_store && !op_q.fault) begin
            buf_valid_q <= 1'b1;
            buf_addr_q <= op_q.alu;
            buf_value_q <= store_mask(op_q.sdata, op_q.size);
            buf_size_q <= op_q.size;
        end
    end
`else
    assign fwd_hit = 1'b0;
    assign ld_dword = bus.dresp_data;
`endif

    load_align u_align (
        .dword_i(ld_dword),
        .lane_i(cur.alu[2:0]),
        .size_i(cur.size),
        .unsigned_i(cur.uns),
        .data_o(ld_ext)
    );

    always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;

    always_comb begin
        state_d = state_q;
        bus.exmem_stall = state_q != IDLE;
        bus.dreq_valid = state_q == REQ;
        bus.dreq_addr = state_q == REQ ? {op_q.alu[XLEN-1:3], 3'b000} : '0;
        case (state_q)
            IDLE: if (bus.exmem_valid) state_d = op_in.is_load && !op_in.fault && !fwd_hit ? REQ : RESP;
            REQ: if (bus.dreq_ready) state_d = WAIT;
            WAIT: if (bus.dresp_valid) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) op_q <= '0;
        else if (state_q == IDLE && bus.exmem_valid) op_q <= op_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dest_q <= '0;
            alu_q <= '0;
            ld_q <= '0;
            dsel_q <= 1'b0;
            wb_q <= 1'b0;
            ecall_q <= 1'b0;
            pw_q <= 1'b0;
            size_q <= '0;
            value_q <= '0;
            addr_q <= '0;
            fault_q <= 1'b0;
        end else if (resp_enter) begin
            dest_q <= cur.rd;
            alu_q <= cur.alu;
            ld_q <= cur.is_load && !cur.fault ? ld_ext : '0;
            dsel_q <= cur.is_load;
            wb_q <= cur.wb;
            ecall_q <= cur.ecall;
            pw_q <= cur.is_store && !cur.fault;
            size_q <= cur.size;
            value_q <= store_mask(cur.sdata, cur.size);
            addr_q <= cur.alu;
            fault_q <= cur.fault;
        end
    end

    assign bus.MEMWB_ready = state_q == RESP;
    assign bus.MEMWB_pend_write = state_q == RESP && pw_q;
    assign bus.MEMWB_ecall = state_q == RESP && ecall_q;
    assign bus.MEMWB_dest_reg = dest_q;
    assign bus.MEMWB_aluresult = alu_q;
    assign bus.MEMWB_loadeddata = ld_q;
    assign bus.MEMWB_dataselect = dsel_q;
    assign bus.MEMWB_wbactive = wb_q;
    assign bus.MEMWB_size = size_q;
    assign bus.MEMWB_value = value_q;
    assign bus.MEMWB_addr = addr_q;
    assign bus.MEMWB_fault = fault_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with hand-computed expectations.
module tb_mem_stage;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;

    mem_stage_if bus();
    mem_stage dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] rd, input logic [63:0] alu, input logic [63:0] sdata,
                        input logic ld, input logic st, input logic [3:0] size,
                        input logic uns, input logic wb, input logic ec);
        bus.exmem_valid = 1'b1;
        bus.exmem_rd = rd;
        bus.exmem_aluresult = alu;
        bus.exmem_store_data = sdata;
        bus.exmem_is_load = ld;
        bus.exmem_is_store = st;
        bus.exmem_size = size;
        bus.exmem_unsigned = uns;
        bus.exmem_wbactive = wb;
        bus.exmem_ecall = ec;
        tick();
        bus.exmem_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.exmem_valid = 1'b0;
        bus.exmem_rd = '0;
        bus.exmem_aluresult = '0;
        bus.exmem_store_data = '0;
        bus.exmem_is_load = 1'b0;
        bus.exmem_is_store = 1'b0;
        bus.exmem_size = '0;
        bus.exmem_unsigned = 1'b0;
        bus.exmem_wbactive = 1'b0;
        bus.exmem_ecall = 1'b0;
        bus.dreq_ready = 1'b0;
        bus.dresp_valid = 1'b0;
        bus.dresp_data = '0;
        tick();
        tick();
        check("rst_ready", 64'(bus.MEMWB_ready), 64'd0);
        check("rst_stall", 64'(bus.exmem_stall), 64'd0);
        check("rst_dreq", 64'(bus.dreq_valid), 64'd0);
        check("rst_dest", 64'(bus.MEMWB_dest_reg), 64'd0);
        check("rst_ld", bus.MEMWB_loadeddata, 64'd0);
        reset = 1'b0;
        tick();

        send(6'd5, 64'h1234, 64'h0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
        check("alu_ready", 64'(bus.MEMWB_ready), 64'd1);
        check("alu_dest", 64'(bus.MEMWB_dest_reg), 64'd5);
        check("alu_result", bus.MEMWB_aluresult, 64'h1234);
        check("alu_dsel", 64'(bus.MEMWB_dataselect), 64'd0);
        check("alu_wb", 64'(bus.MEMWB_wbactive), 64'd1);
        check("alu_dreq", 64'(bus.dreq_valid), 64'd0);
        check("alu_stall", 64'(bus.exmem_stall), 64'd1);
        check("alu_pend", 64'(bus.MEMWB_pend_write), 64'd0);
        tick();
        check("alu_ready_drop", 64'(bus.MEMWB_ready), 64'd0);
        check("alu_idle_stall", 64'(bus.exmem_stall), 64'd0);
        check("alu_dest_hold", 64'(bus.MEMWB_dest_reg), 64'd5);

        send(6'd0, 64'h0, 64'h0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1);
        check("ecall_on", 64'(bus.MEMWB_ecall), 64'd1);
        tick();
        check("ecall_off", 64'(bus.MEMWB_ecall), 64'd0);

        bus.dresp_valid = 1'b1;
        bus.dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        send(6'd3, 64'h1003, 64'h0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
        check("lb_dreq", 64'(bus.dreq_valid), 64'd1);
        check("lb_daddr", bus.dreq_addr, 64'h1000);
        check("lb_stall_req", 64'(bus.exmem_stall), 64'd1);
        check("lb_not_ready", 64'(bus.MEMWB_ready), 64'd0);
        tick();
        check("lb_dreq_hold", 64'(bus.dreq_valid), 64'd1);
        bus.dreq_ready = 1'b1;
        bus.dresp_valid = 1'b0;
        tick();
        bus.dreq_ready = 1'b0;
        check("lb_wait_dreq", 64'(bus.dreq_valid), 64'd0);
        check("lb_wait_stall", 64'(bus.exmem_stall), 64'd1);
        tick();
        check("lb_wait_ready", 64'(bus.MEMWB_ready), 64'd0);
        bus.dresp_valid = 1'b1;
        bus.dresp_data = 64'h0000_0000_8000_0000;
        tick();
        bus.dresp_valid = 1'b0;
        check("lb_ready", 64'(bus.MEMWB_ready), 64'd1);
        check("lb_data", bus.MEMWB_loadeddata, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_dsel", 64'(bus.MEMWB_dataselect), 64'd1);
        check("lb_dest", 64'(bus.MEMWB_dest_reg), 64'd3);
        check("lb_stall_resp", 64'(bus.exmem_stall), 64'd1);
        tick();
        check("lb_idle_stall", 64'(bus.exmem_stall), 64'd0);

        send(6'd0, 64'h2004, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        check("sw_pend", 64'(bus.MEMWB_pend_write), 64'd1);
        check("sw_addr", bus.MEMWB_addr, 64'h2004);
        check("sw_size", 64'(bus.MEMWB_size), 64'd4);
        check("sw_value", bus.MEMWB_value, 64'h0000_0000_CAFE_F00D);
        check("sw_dreq", 64'(bus.dreq_valid), 64'd0);
        check("sw_fault", 64'(bus.MEMWB_fault), 64'd0);
        tick();
        check("sw_pend_drop", 64'(bus.MEMWB_pend_write), 64'd0);
        check("sw_value_hold", bus.MEMWB_value, 64'h0000_0000_CAFE_F00D);

        send(6'd9, 64'h1002, 64'h0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0);
        check("mis_ready", 64'(bus.MEMWB_ready), 64'd1);
        check("mis_fault", 64'(bus.MEMWB_fault), 64'd1);
        check("mis_wb", 64'(bus.MEMWB_wbactive), 64'd0);
        check("mis_dreq", 64'(bus.dreq_valid), 64'd0);
        tick();

        send(6'd9, 64'h1000, 64'h77, 1'b1, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0);
        check("ldst_fault", 64'(bus.MEMWB_fault), 64'd1);
        check("ldst_pend", 64'(bus.MEMWB_pend_write), 64'd0);
        check("ldst_dsel", 64'(bus.MEMWB_dataselect), 64'd1);
        check("ldst_wb", 64'(bus.MEMWB_wbactive), 64'd0);
        tick();

        send(6'd0, 64'h2001, 64'h1234, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        check("missh_fault", 64'(bus.MEMWB_fault), 64'd1);
        check("missh_pend", 64'(bus.MEMWB_pend_write), 64'd0);
        tick();
        send(6'd0, 64'h3000, 64'h1122_3344_5566_7788, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        check("sd_value", bus.MEMWB_value, 64'h1122_3344_5566_7788);
        tick();
        send(6'd4, 64'h3002, 64'h0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0);
`ifdef MEM_STORE_FWD_EN
        check("fwd_ready", 64'(bus.MEMWB_ready), 64'd1);
        check("fwd_dreq", 64'(bus.dreq_valid), 64'd0);
        check("fwd_data", bus.MEMWB_loadeddata, 64'h5566);
`else
        check("nofwd_dreq", 64'(bus.dreq_valid), 64'd1);
        check("nofwd_daddr", bus.dreq_addr, 64'h3000);
        bus.dreq_ready = 1'b1;
        tick();
        bus.dreq_ready = 1'b0;
        bus.dresp_valid = 1'b1;
        bus.dresp_data = 64'h1122_3344_5566_7788;
        tick();
        bus.dresp_valid = 1'b0;
        check("nofwd_ready", 64'(bus.MEMWB_ready), 64'd1);
        check("nofwd_data", bus.MEMWB_loadeddata, 64'h5566);
`endif
        tick();

        send(6'd2, 64'h4006, 64'h0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
        bus.dreq_ready = 1'b1;
        tick();
        bus.dreq_ready = 1'b0;
        bus.dresp_valid = 1'b1;
        bus.dresp_data = 64'h8001_0000_0000_0000;
        tick();
        bus.dresp_valid = 1'b0;
        check("lh_ready_min", 64'(bus.MEMWB_ready), 64'd1);
        check("lh_data", bus.MEMWB_loadeddata, 64'hFFFF_FFFF_FFFF_8001);
        tick();

        send(6'd6, 64'h5000, 64'h0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
        bus.dreq_ready = 1'b1;
        tick();
        bus.dreq_ready = 1'b0;
        check("rw_in_wait", 64'(bus.dreq_valid), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_ready", 64'(bus.MEMWB_ready), 64'd0);
        check("rw_stall", 64'(bus.exmem_stall), 64'd0);
        check("rw_dest", 64'(bus.MEMWB_dest_reg), 64'd0);
        check("rw_alu", bus.MEMWB_aluresult, 64'd0);
        check("rw_value", bus.MEMWB_value, 64'd0);
        check("rw_dsel", 64'(bus.MEMWB_dataselect), 64'd0);
        send(6'd7, 64'h55, 64'h0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
        check("rw_new_ready", 64'(bus.MEMWB_ready), 64'd1);
        check("rw_new_dest", 64'(bus.MEMWB_dest_reg), 64'd7);
        check("rw_new_alu", bus.MEMWB_aluresult, 64'h55);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
